turn_controller: RTL and testbench
==================================

TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 4, number of active players (legal 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, WAIT cycles before a turn is forfeited (used only with TURN_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1, system clock; single clock domain; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, level; begins a new game from IDLE or OVER.
REQ-006 SHALL have port pick, input, 1, player card-pick button, level; only its rising edge is used.
REQ-007 SHALL have port match, input, 1, picked card matches the target tile; sampled in the same cycle as the pick rising edge.
REQ-008 SHALL have port win, input, 1, win flag from the position/win checker; sampled only in CHECK.
REQ-009 SHALL have port T, output, 2, current player index, driving the position datapath select.
REQ-010 SHALL have port move_en, output, 1, one-cycle pulse that advances player T's position counter.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE and OVER.
REQ-012 SHALL have port game_over, output, 1, high in OVER.
REQ-013 SHALL have port winner, output, 2, index of the winning player; valid while game_over is high.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, MOVE, CHECK, NEXT and OVER, all registered.
REQ-015 SHALL detect the pick rising edge as pick & ~pick_q, where pick_q is pick registered once.
- pick held high SHALL yield exactly one edge.
REQ-016 SHALL take these transitions from IDLE and WAIT:
- IDLE, start=1: go to WAIT; T=0.
- WAIT, pick edge with match=1: go to MOVE.
- WAIT, pick edge with match=0: go to NEXT.
- WAIT, no pick edge: stay in WAIT.
REQ-017 SHALL assert move_en only in MOVE, always for exactly one cycle, one cycle after the pick edge; MOVE then goes to CHECK.
REQ-018 SHALL sample win in CHECK:
- win=1: go to OVER; winner=T.
- win=0: return to WAIT with T unchanged (the player keeps the turn).
REQ-019 SHALL, in NEXT, set T=(T+1) mod NUM_PLAYERS and go to WAIT; NEXT lasts one cycle.
REQ-020 SHALL wrap T from NUM_PLAYERS-1 to 0; T SHALL never reach NUM_PLAYERS or above.
REQ-021 SHALL hold T and winner in OVER; start=1 in OVER restarts the game (WAIT, T=0, winner=0).
REQ-022 SHALL ignore pick edges outside WAIT.
- An edge arriving in MOVE, CHECK or NEXT SHALL NOT be queued.
REQ-023 SHALL ignore start in WAIT, MOVE, CHECK and NEXT.
REQ-024 SHALL ignore win outside CHECK.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set: state=IDLE, T=0, winner=0, move_en=0, busy=0, game_over=0, pick_q=0 and timeout counter=0.
REQ-026 SHALL give rst priority over every other input; rst mid-turn (including in MOVE) SHALL suppress any pending move_en.

Configuration
REQ-027 SHALL, when TURN_TIMEOUT_EN is defined, implement a WAIT-cycle counter:
- clears on entry to WAIT;
- on reaching TIMEOUT_CYCLES-1 with no pick edge, the FSM goes to NEXT (turn forfeited, no move_en);
- a pick edge in the same cycle as the timeout wins.
REQ-028 SHALL, when TURN_TIMEOUT_EN is not defined, contain no counter logic, and WAIT SHALL last indefinitely.

Structure
REQ-029 SHALL import shared package game_pkg, which holds:
- state enum typedef;
- player_t (2-bit) typedef;
- MAX_PLAYERS=4 constant.
REQ-030 SHALL instantiate one sub-module, btn_edge, that contains pick_q and the rising-edge detect.

Verification
REQ-031 SHALL be covered by directed scenarios with clock-exact checks:
- rst, then start pulse -> WAIT, T=0, busy=1, move_en=0.
- T=0, pick edge with match=1, win=0 in CHECK -> move_en high exactly 1 cycle (one after edge); back in WAIT with T=0.
- NUM_PLAYERS=3, four pick edges with match=0 -> T sequence 1,2,0,1; move_en never asserted.
- T=2, pick edge with match=1, win=1 in CHECK -> OVER, game_over=1, winner=2, busy=0; later pick edges ignored; start -> WAIT, T=0.
- Edge timing: pick held high 10 cycles -> single move; rst asserted in MOVE -> move_en=0 next cycle and all outputs at reset values.
- TURN_TIMEOUT_EN with TIMEOUT_CYCLES=8, T=1, no pick -> after 8 WAIT cycles T=2, no move_en; pick in the timeout cycle -> pick processed, no forfeit.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the board-game turn controller.
package game_pkg;

   localparam int MAX_PLAYERS = 4;

   typedef logic [1:0] player_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_MOVE,
      S_CHECK,
      S_NEXT,
      S_OVER
   } state_t;

   // Round-robin successor; wraps at the configured player count, not at MAX_PLAYERS.
   function automatic player_t next_player(input player_t cur, input int num);
      player_t nxt;
      if (int'(cur) >= num - 1) nxt = '0;
      else                      nxt = cur + 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for the card-pick button: one pulse per press, however long it is held.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic pick,
   output logic rise
);

   logic pick_q;

   always_ff @(posedge clk) begin
      if (rst) pick_q <= 1'b0;
      else     pick_q <= pick;
   end

   assign rise = pick & ~pick_q;

endmodule

// File: rtl/turn_controller.sv
// Turn sequencing FSM for up to four players. Optional WAIT forfeit timer
// is built when the macro TURN_TIMEOUT_EN is defined.
module turn_controller
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS    = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pick,
   input  logic       match,
   input  logic       win,
   output logic [1:0] T,
   output logic       move_en,
   output logic       busy,
   output logic       game_over,
   output logic [1:0] winner
);

   if (NUM_PLAYERS < 2 || NUM_PLAYERS > MAX_PLAYERS || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("turn_controller: illegal NUM_PLAYERS or TIMEOUT_CYCLES");
   end

   state_t  state, state_nx;
   player_t t_q, winner_q;
   logic    pick_rise;
   logic    timeout_hit;

   btn_edge u_btn_edge (
      .clk  (clk),
      .rst  (rst),
      .pick (pick),
      .rise (pick_rise)
   );

`ifdef TURN_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wait_cnt;

   // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
   always_ff @(posedge clk) begin
      if (rst || state != S_WAIT) wait_cnt <= '0;
      else if (!timeout_hit)      wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_WAIT;
         // A pick edge takes precedence over a simultaneous timeout.
         S_WAIT: begin
            if (pick_rise)        state_nx = match ? S_MOVE : S_NEXT;
            else if (timeout_hit) state_nx = S_NEXT;
         end
         S_MOVE:  state_nx = S_CHECK;
         S_CHECK: state_nx = win ? S_OVER : S_WAIT;
         S_NEXT:  state_nx = S_WAIT;
         S_OVER:  if (start) state_nx = S_WAIT;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_q      <= '0;
         winner_q <= '0;
      end else begin
         case (state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  t_q      <= '0;
                  winner_q <= '0;
               end
            end
            S_CHECK: if (win) winner_q <= t_q;
            S_NEXT:  t_q <= next_player(t_q, NUM_PLAYERS);
            default: ;
         endcase
      end
   end

   assign T         = t_q;
   assign winner    = winner_q;
   assign move_en   = (state == S_MOVE);
   assign game_over = (state == S_OVER);
   assign busy      = (state != S_IDLE) && (state != S_OVER);

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: vector table, directed corner sequences
// and a randomized run against a turn-level model of the game rules.
module tb_turn_controller;

   localparam int NP = 3;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst, start, pick, match, win;
   logic [1:0] t, winner;
   logic       move_en, busy, game_over;

   int n_tests = 0;
   int n_fail  = 0;

   turn_controller #(.NUM_PLAYERS(NP), .TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pick      (pick),
      .match     (match),
      .win       (win),
      .T         (t),
      .move_en   (move_en),
      .busy      (busy),
      .game_over (game_over),
      .winner    (winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, start, pick, match, win;
      logic [1:0] t;
      logic       mv, busy, go;
      logic [1:0] wn;
   } vec_t;

   vec_t vecs[$];

   function automatic void addv(input logic r, s, p, m, w,
                                input logic [1:0] et, input logic emv, eb, ego,
                                input logic [1:0] ewn);
      vec_t v;
      v.rst = r; v.start = s; v.pick = p; v.match = m; v.win = w;
      v.t = et; v.mv = emv; v.busy = eb; v.go = ego; v.wn = ewn;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [1:0] et, input logic emv,
                             input logic eb, input logic ego, input logic [1:0] ewn);
      check({name, "_T"},         32'(t),         32'(et));
      check({name, "_move_en"},   32'(move_en),   32'(emv));
      check({name, "_busy"},      32'(busy),      32'(eb));
      check({name, "_game_over"}, 32'(game_over), 32'(ego));
      check({name, "_winner"},    32'(winner),    32'(ewn));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, first_mv, player, over, win_by, idle;
      logic m, w;

      rst = 1'b1; start = 1'b0; pick = 1'b0; match = 1'b0; win = 1'b0;

      //   rst start pick match win |  T  mv busy go wn
      addv(1, 0, 0, 0, 0,  2'd0, 0, 0, 0, 2'd0);  // reset
      addv(0, 0, 0, 0, 0,  2'd0, 0, 0, 0, 2'd0);  // IDLE holds
      addv(0, 1, 0, 0, 0,  2'd0, 0, 1, 0, 2'd0);  // start -> WAIT
      addv(0, 0, 1, 1, 0,  2'd0, 1, 1, 0, 2'd0);  // edge, match -> MOVE
      addv(0, 0, 1, 0, 1,  2'd0, 0, 1, 0, 2'd0);  // win ignored in MOVE -> CHECK
      addv(0, 0, 0, 0, 0,  2'd0, 0, 1, 0, 2'd0);  // win=0 -> WAIT, keeps turn
      addv(0, 0, 1, 0, 0,  2'd0, 0, 1, 0, 2'd0);  // miss -> NEXT
      addv(0, 0, 0, 0, 0,  2'd1, 0, 1, 0, 2'd0);
      addv(0, 0, 1, 0, 0,  2'd1, 0, 1, 0, 2'd0);
      addv(0, 0, 0, 0, 0,  2'd2, 0, 1, 0, 2'd0);
      addv(0, 0, 1, 0, 0,  2'd2, 0, 1, 0, 2'd0);
      addv(0, 0, 0, 0, 0,  2'd0, 0, 1, 0, 2'd0);  // wrap 2 -> 0
      addv(0, 0, 1, 0, 0,  2'd0, 0, 1, 0, 2'd0);
      addv(0, 0, 0, 0, 0,  2'd1, 0, 1, 0, 2'd0);
      addv(0, 1, 1, 0, 0,  2'd1, 0, 1, 0, 2'd0);  // start ignored in WAIT
      addv(0, 0, 0, 0, 0,  2'd2, 0, 1, 0, 2'd0);
      addv(0, 0, 1, 1, 0,  2'd2, 1, 1, 0, 2'd0);  // T=2 hit -> MOVE
      addv(0, 1, 0, 0, 0,  2'd2, 0, 1, 0, 2'd0);  // start ignored in MOVE
      addv(0, 0, 0, 0, 1,  2'd2, 0, 0, 1, 2'd2);  // win -> OVER
      addv(0, 0, 1, 1, 0,  2'd2, 0, 0, 1, 2'd2);  // pick ignored in OVER
      addv(0, 0, 0, 0, 0,  2'd2, 0, 0, 1, 2'd2);
      addv(0, 0, 1, 1, 0,  2'd2, 0, 0, 1, 2'd2);
      addv(0, 1, 0, 0, 0,  2'd0, 0, 1, 0, 2'd0);  // restart
      addv(0, 1, 0, 0, 0,  2'd0, 0, 1, 0, 2'd0);
      addv(0, 0, 1, 1, 0,  2'd0, 1, 1, 0, 2'd0);  // MOVE
      addv(1, 0, 0, 0, 0,  2'd0, 0, 0, 0, 2'd0);  // rst in MOVE
      addv(0, 0, 0, 0, 0,  2'd0, 0, 0, 0, 2'd0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; start = vecs[i].start; pick = vecs[i].pick;
         match = vecs[i].match; win = vecs[i].win;
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].t, vecs[i].mv, vecs[i].busy,
                    vecs[i].go, vecs[i].wn);
      end
      rst = 1'b0; start = 1'b0; pick = 1'b0; match = 1'b0; win = 1'b0;

      // Held pick: exactly one move, issued the cycle after the edge.
      start = 1'b1; tick(); start = 1'b0;
      check_outs("held_start", 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
      pick = 1'b1; match = 1'b1;
      pulses = 0; first_mv = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         pulses += int'(move_en);
         if (i == 0) first_mv = int'(move_en);
      end
      check("held_first_cycle", 32'(first_mv), 32'd1);
      check("held_pulses", 32'(pulses), 32'd1);
      pick = 1'b0; tick();
      check_outs("held_end", 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);

      // Edge arriving in CHECK must not be queued into the following WAIT.
      pick = 1'b1; match = 1'b1; tick();
      check("noq_move", 32'(move_en), 32'd1);
      pick = 1'b0; tick();
      pick = 1'b1; win = 1'b0; tick();
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         pulses += int'(move_en);
      end
      check("noq_pulses", 32'(pulses), 32'd0);
      check_outs("noq_end", 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
      pick = 1'b0; tick();

      pick = 1'b1; match = 1'b0; tick(); pick = 1'b0; tick();
      check("to_setup_T", 32'(t), 32'd1);

`ifdef TURN_TIMEOUT_EN
      pulses = 0;
      for (int i = 0; i < TO; i++) begin
         tick();
         pulses += int'(move_en);
      end
      check("to_not_early_T", 32'(t), 32'd1);
      tick();
      check("to_forfeit_T", 32'(t), 32'd2);
      check("to_forfeit_moves", 32'(pulses), 32'd0);
      for (int i = 0; i < TO - 1; i++) tick();
      pick = 1'b1; match = 1'b1; win = 1'b0; tick();
      check("to_pick_wins_mv", 32'(move_en), 32'd1);
      pick = 1'b0; tick(); tick();
      check_outs("to_pick_wins_end", 2'd2, 1'b0, 1'b1, 1'b0, 2'd0);
`else
      pulses = 0;
      for (int i = 0; i < 3 * TO; i++) begin
         tick();
         pulses += int'(move_en);
      end
      check("no_to_moves", 32'(pulses), 32'd0);
      check_outs("no_to_wait", 2'd1, 1'b0, 1'b1, 1'b0, 2'd0);
`endif

      // Randomized turns against a turn-level model of the rules.
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      player = 0; over = 0; win_by = 0;
      for (int k = 0; k < 60; k++) begin
         idle = int'($urandom_range(0, 5));
         pulses = 0;
         for (int i = 0; i < idle; i++) begin
            tick();
            pulses += int'(move_en);
         end
         check($sformatf("rnd%0d_idle_moves", k), 32'(pulses), 32'd0);
         m = 1'($urandom_range(0, 1));
         w = ($urandom_range(0, 3) == 0);
         pick = 1'b1; match = m; win = w;
         tick();
         check($sformatf("rnd%0d_mv", k), 32'(move_en), 32'(m));
         pick = 1'b0;
         if (m) begin
            tick();
            check($sformatf("rnd%0d_mv_once", k), 32'(move_en), 32'd0);
         end
         tick();
         win = 1'b0;
         if (m && w) begin
            over = 1;
            win_by = player;
         end else if (!m) begin
            player = (player + 1) % NP;
         end
         check_outs($sformatf("rnd%0d", k), 2'(player), 1'b0, 1'(!over), 1'(over),
                    over ? 2'(win_by) : 2'd0);
         if (over != 0) begin
            start = 1'b1; tick(); start = 1'b0;
            player = 0; over = 0; win_by = 0;
            check_outs($sformatf("rnd%0d_restart", k), 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
